// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter slice.
//   uart_state_e    : transmitter frame phases (idle, start bit, data bits, stop bit)
//   UART_DATA_BITS  : data bits per frame
//   UART_FRAME_BITS : start + data + stop bits per frame
//   uart_byte_t     : one payload byte
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte write port of the UART transmitter (valid/ready handshake).
//   wr_valid : producer offers wr_data
//   wr_data  : byte to transmit
//   wr_ready : transmitter FIFO has room; transfer happens when both are high at an edge
// Modports: master = byte producer, slave = transmitter.
interface uart_transmitter_if;
    import uart_pkg::*;

    logic       wr_valid;
    uart_byte_t wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data.
//   core_clk/core_rst : clock and synchronous active-high reset
//   push/push_data    : write request; ignored while full
//   pop/pop_data      : read request; ignored while empty; pop_data shows the head entry
//   full/empty/level  : occupancy status, level counts 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             push,
    input  uart_byte_t       push_data,
    input  logic             pop,
    output uart_byte_t       pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    uart_byte_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because level guards every read.
    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves level unchanged.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a byte FIFO and programmable baud divisor.
//   core_clk/core_rst : clock and synchronous active-high reset
//   enable            : gates the start of new frames; a frame in flight always completes
//   divisor           : core_clk cycles per bit, sampled at frame start (0 acts as 1)
//   wr                : valid/ready byte write port (slave side)
//   ser_tx            : registered serial output, idle high, LSB first
//   busy              : frame in flight or bytes queued
//   fifo_level        : current FIFO occupancy
module uart_transmitter
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    parameter  int DIV_W      = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] divisor,
    uart_transmitter_if.slave wr,
    output logic             ser_tx,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] START = ST_START;
    localparam logic [1:0] DATA  = ST_DATA;
    localparam logic [1:0] STOP  = ST_STOP;

    localparam int                 IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0]   LAST_BIT = IDX_W'(UART_DATA_BITS - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);

    logic [1:0]       state;
    uart_byte_t       shift_reg;
    uart_byte_t       fifo_dout;
    logic [IDX_W-1:0] bit_idx;
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_eff;
    logic             fifo_full;
    logic             fifo_empty;
    logic             baud_done;
    logic             start_frame;

    assign div_eff   = (divisor == '0) ? DIV_ONE : divisor;
    assign baud_done = (baud_cnt == '0);

    // A new frame begins from IDLE, or on the last cycle of a stop bit so
    // back-to-back frames leave no idle gap. The same condition pops the FIFO.
    assign start_frame = enable && !fifo_empty &&
                         ((state == IDLE) || ((state == STOP) && baud_done));

    assign wr.wr_ready = !fifo_full;
    assign busy        = (state != IDLE) || (fifo_level != '0);

    uart_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk  (core_clk),
        .core_rst  (core_rst),
        .push      (wr.wr_valid),
        .push_data (wr.wr_data),
        .pop       (start_frame),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Frame sequencer: baud_cnt counts down the cycles left in the current bit,
    // reloaded from div_q so every bit lasts exactly div_q cycles. The shift
    // register presents the next data bit at shift_reg[0].
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            div_q     <= DIV_ONE;
            ser_tx    <= 1'b1;
        end else if (start_frame) begin
            state     <= START;
            shift_reg <= fifo_dout;
            div_q     <= div_eff;
            baud_cnt  <= div_eff - DIV_ONE;
            ser_tx    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ser_tx <= 1'b1;
                end
                START: begin
                    if (baud_done) begin
                        state     <= DATA;
                        ser_tx    <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                        bit_idx   <= '0;
                        baud_cnt  <= div_q - DIV_ONE;
                    end else begin
                        baud_cnt <= baud_cnt - DIV_ONE;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= div_q - DIV_ONE;
                        if (bit_idx == LAST_BIT) begin
                            state  <= STOP;
                            ser_tx <= 1'b1;
                        end else begin
                            ser_tx    <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                            bit_idx   <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - DIV_ONE;
                    end
                end
                STOP: begin
                    ser_tx <= 1'b1;
                    if (baud_done) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - DIV_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ser_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter: drives the write port
// through the interface and decodes ser_tx cycle by cycle against
// hand-computed 8N1 frames.
module tb_uart_transmitter;

    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic             core_clk;
    logic             core_rst;
    logic             enable;
    logic [DIV_W-1:0] divisor;
    logic             ser_tx;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    uart_transmitter_if wr_if ();

    int checkCount;
    int errorCount;
    int cycleCount;
    int lastWait;
    int frameStart;
    logic [7:0] lastByte;

    uart_transmitter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .enable     (enable),
        .divisor    (divisor),
        .wr         (wr_if),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    // 10 ns clock.
    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // Free-running edge counter used for timing checks.
    initial cycleCount = 0;
    always @(posedge core_clk) cycleCount <= cycleCount + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one byte and wait (bounded) for its acceptance edge; returns #1
    // after that edge. With hold=1, wr_valid stays high for a following write.
    task automatic applyStimulus(input logic [7:0] data, input bit hold, output int acceptCycle);
        bit accepted;
        accepted    = 1'b0;
        acceptCycle = -1;
        @(negedge core_clk);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = data;
        for (int i = 0; i < 400; i++) begin
            if (wr_if.wr_ready === 1'b1) begin
                @(posedge core_clk);
                accepted = 1'b1;
                break;
            end
            @(negedge core_clk);
        end
        #1;
        acceptCycle = cycleCount;
        if (!hold || !accepted) begin
            wr_if.wr_valid = 1'b0;
        end
        if (!accepted) begin
            checkOutput("write_accept_timeout", 32'd0, 32'd1);
        end
    endtask

    // Wait (bounded) for a start bit, then sample every cycle of the frame at
    // negedges. Checks the 10 bit values and that each bit is flat for div cycles.
    task automatic expectFrame(input logic [7:0] data, input int div, input int budget,
                               input string tag);
        logic [9:0] obs;
        logic       first;
        int         unstable;
        bit         found;
        found    = 1'b0;
        lastWait = 0;
        obs      = '1;
        for (int i = 0; i < budget; i++) begin
            @(negedge core_clk);
            lastWait = i + 1;
            if (ser_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_start"}, 32'(found), 32'd1);
        if (!found) return;
        frameStart = cycleCount;
        unstable   = 0;
        for (int b = 0; b < 10; b++) begin
            if (b != 0) @(negedge core_clk);
            first  = ser_tx;
            obs[b] = first;
            for (int c = 1; c < div; c++) begin
                @(negedge core_clk);
                if (ser_tx !== first) unstable++;
            end
        end
        lastByte = obs[8:1];
        checkOutput({tag, "_bits"}, 32'(obs), 32'({1'b1, data, 1'b0}));
        checkOutput({tag, "_stable"}, 32'(unstable), 32'd0);
    endtask

    // Bounded wait for ser_tx to go low, sampled at negedges.
    task automatic waitForFall(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge core_clk);
            if (ser_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_fall"}, 32'(found), 32'd1);
    endtask

    initial begin
        int acc;
        int acc16;
        int firstStart;
        int endCycle;
        int lowCount;
        string msg;
        string rxText;

        checkCount     = 0;
        errorCount     = 0;
        core_rst       = 1'b1;
        enable         = 1'b1;
        divisor        = 16'd4;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;

        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        core_rst = 1'b0;
        checkOutput("reset_ser_tx", 32'(ser_tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_level", 32'(fifo_level), 32'd0);
        checkOutput("reset_ready", 32'(wr_if.wr_ready), 32'd1);

        // Single frame 0x55 at divisor 4, start bit one edge after accept.
        $display("[TB] single frame 0x55, divisor 4");
        applyStimulus(8'h55, 1'b0, acc);
        expectFrame(8'h55, 4, 2, "single");
        checkOutput("single_latency", 32'(lastWait), 32'd2);
        @(negedge core_clk);
        checkOutput("single_busy_after", 32'(busy), 32'd0);
        checkOutput("single_idle_line", 32'(ser_tx), 32'd1);

        // Fill the FIFO with enable low, then stream all 17 bytes back to back.
        $display("[TB] fill FIFO and stream 17 bytes, divisor 2");
        @(negedge core_clk);
        enable  = 1'b0;
        divisor = 16'd2;
        for (int b = 0; b < 16; b++) begin
            applyStimulus(8'(b), 1'b1, acc);
        end
        checkOutput("full_level", 32'(fifo_level), 32'd16);
        checkOutput("full_ready", 32'(wr_if.wr_ready), 32'd0);
        firstStart = 0;
        endCycle   = 0;
        acc16      = -1;
        fork
            applyStimulus(8'h10, 1'b0, acc16);
            begin
                repeat (4) @(negedge core_clk);
                checkOutput("full_hold_level", 32'(fifo_level), 32'd16);
                checkOutput("full_hold_ready", 32'(wr_if.wr_ready), 32'd0);
                enable = 1'b1;
            end
            begin
                expectFrame(8'h00, 2, 20, "b2b_00");
                firstStart = frameStart;
                for (int b = 1; b < 17; b++) begin
                    expectFrame(8'(b), 2, 1, $sformatf("b2b_%02h", b));
                end
                endCycle = cycleCount;
            end
        join
        checkOutput("refill_after_pop", 32'(acc16), 32'(firstStart + 1));
        checkOutput("b2b_total_cycles", 32'(endCycle - firstStart + 1), 32'd340);
        @(negedge core_clk);
        checkOutput("b2b_busy_after", 32'(busy), 32'd0);

        // Divisor 0 behaves as 1.
        $display("[TB] divisor 0 acts as 1");
        divisor = 16'd0;
        applyStimulus(8'hA3, 1'b0, acc);
        expectFrame(8'hA3, 1, 2, "div0");
        repeat (3) @(negedge core_clk);

        // Divisor change during bit 4 affects only the following frame.
        $display("[TB] divisor 8 -> 3 mid-frame");
        divisor = 16'd8;
        applyStimulus(8'h5A, 1'b1, acc);
        applyStimulus(8'h96, 1'b0, acc);
        fork
            begin
                expectFrame(8'h5A, 8, 3, "divchg_a");
                expectFrame(8'h96, 3, 1, "divchg_b");
            end
            begin
                waitForFall("divchg");
                repeat (43) @(negedge core_clk);
                divisor = 16'd3;
            end
        join
        repeat (3) @(negedge core_clk);

        // Enable gating holds bytes in the FIFO until enable rises.
        $display("[TB] enable gating");
        enable = 1'b0;
        applyStimulus(8'h3C, 1'b1, acc);
        applyStimulus(8'hC3, 1'b0, acc);
        repeat (5) @(negedge core_clk);
        checkOutput("gate_ser_tx", 32'(ser_tx), 32'd1);
        checkOutput("gate_level", 32'(fifo_level), 32'd2);
        checkOutput("gate_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        expectFrame(8'h3C, 3, 3, "gate_a");
        expectFrame(8'hC3, 3, 1, "gate_b");
        @(negedge core_clk);
        checkOutput("gate_busy_after", 32'(busy), 32'd0);

        // Reset during bit 3 aborts the frame and flushes the queue.
        $display("[TB] reset mid-frame");
        divisor = 16'd10;
        applyStimulus(8'hFF, 1'b1, acc);
        applyStimulus(8'h01, 1'b0, acc);
        waitForFall("rstmid");
        repeat (45) @(negedge core_clk);
        core_rst = 1'b1;
        @(negedge core_clk);
        core_rst = 1'b0;
        checkOutput("rstmid_ser_tx", 32'(ser_tx), 32'd1);
        checkOutput("rstmid_level", 32'(fifo_level), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_ready", 32'(wr_if.wr_ready), 32'd1);
        lowCount = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge core_clk);
            if (ser_tx !== 1'b1) lowCount++;
        end
        checkOutput("rstmid_line_quiet", 32'(lowCount), 32'd0);

        // Loopback text through the frame decoder at divisor 4.
        $display("[TB] loopback \"UART\"");
        divisor = 16'd4;
        msg     = "UART";
        rxText  = "";
        fork
            for (int i = 0; i < 4; i++) begin
                applyStimulus(msg[i], (i != 3), acc);
            end
            for (int i = 0; i < 4; i++) begin
                expectFrame(msg[i], 4, (i == 0) ? 10 : 1, $sformatf("loop_%0d", i));
                checkOutput($sformatf("loop_char_%0d", i), 32'(lastByte), 32'(msg[i]));
                rxText = {rxText, string'(lastByte)};
            end
        join
        $display("[TB] receiver got \"%s\"", rxText);
        @(negedge core_clk);
        checkOutput("loop_busy_after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        errorCount++;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
